// File: rtl/load_unit_ctrl.sv
// load_unit_ctrl: sequencing controller for RV32I loads.
//
// Accepts one decoded load at a time and forms the effective address
// ea = rs1 + sext(imm). A misaligned halfword or word load is reported with
// a one-cycle strobe and never reaches memory. Otherwise the controller
// issues a word-aligned read over a valid/ready request port, waits for the
// response, and extracts and extends the addressed byte, halfword or word
// into a one-cycle register-file write-back.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   ld_valid          load request present
//   ld_ready          controller idle and able to accept a load
//   ld_rs1_data       base register value
//   ld_imm            12-bit signed offset
//   ld_rd             destination register
//   ld_control        load type (LB/LH/LW/LBU/LHU funct3 encodings)
//   mem_req_valid     data-memory read request
//   mem_req_ready     data memory accepts the request
//   mem_addr          word-aligned read address
//   mem_rsp_valid     read data valid
//   mem_rsp_data      little-endian read word
//   wb_valid          one-cycle write-back strobe (suppressed for rd = x0)
//   wb_rd             write-back register
//   wb_data           extended load result
//   misaligned        one-cycle misaligned-load strobe
//   misaligned_addr   offending effective address

module load_unit_ctrl (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_rs1_data,
  input  logic [11:0] ld_imm,
  input  logic [4:0]  ld_rd,
  input  logic [2:0]  ld_control,

  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,

  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,

  output logic        misaligned,
  output logic [31:0] misaligned_addr
);

  // Load encodings (funct3) shared with the load decoder.
  localparam logic [2:0] CtrlLb  = 3'b000;
  localparam logic [2:0] CtrlLh  = 3'b001;
  localparam logic [2:0] CtrlLw  = 3'b010;
  localparam logic [2:0] CtrlLbu = 3'b100;
  localparam logic [2:0] CtrlLhu = 3'b101;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StDone,
    StErr
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        mis_q, mis_d;
  logic [31:0] mis_addr_q, mis_addr_d;

  // Effective address and alignment check on the incoming request.
  logic [31:0] ea;
  logic        ea_misaligned;

  always_comb begin
    ea            = ld_rs1_data + {{20{ld_imm[11]}}, ld_imm};
    ea_misaligned = 1'b0;
    case (ld_control)
      CtrlLb, CtrlLbu: ea_misaligned = 1'b0;
      CtrlLh, CtrlLhu: ea_misaligned = ea[0];
      // LW and every unrecognised encoding need word alignment.
      default:         ea_misaligned = |ea[1:0];
    endcase
  end

  // Lane extraction from the returned word, using the latched byte offset.
  logic [7:0]  rsp_byte;
  logic [15:0] rsp_half;
  logic [31:0] load_result;

  always_comb begin
    rsp_byte = 8'h00;
    case (lane_q)
      2'd0:    rsp_byte = mem_rsp_data[7:0];
      2'd1:    rsp_byte = mem_rsp_data[15:8];
      2'd2:    rsp_byte = mem_rsp_data[23:16];
      default: rsp_byte = mem_rsp_data[31:24];
    endcase

    rsp_half = lane_q[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];

    load_result = mem_rsp_data;
    case (ctrl_q)
      CtrlLb:  load_result = {{24{rsp_byte[7]}}, rsp_byte};
      CtrlLbu: load_result = {24'h000000, rsp_byte};
      CtrlLh:  load_result = {{16{rsp_half[15]}}, rsp_half};
      CtrlLhu: load_result = {16'h0000, rsp_half};
      default: load_result = mem_rsp_data;
    endcase
  end

  // Next-state logic. Strobes default low so they last exactly one cycle.
  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    ctrl_d     = ctrl_q;
    lane_d     = lane_q;
    mem_addr_d = mem_addr_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    mis_d      = 1'b0;
    mis_addr_d = mis_addr_q;

    unique case (state_q)
      StIdle: begin
        if (ld_valid) begin
          rd_d   = ld_rd;
          ctrl_d = ld_control;
          lane_d = ea[1:0];
          if (ea_misaligned) begin
            mis_d      = 1'b1;
            mis_addr_d = ea;
            state_d    = StErr;
          end else begin
            // Address is captured here so it stays stable throughout REQ.
            mem_addr_d = {ea[31:2], 2'b00};
            state_d    = StReq;
          end
        end
      end
      StReq: begin
        if (mem_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (mem_rsp_valid) begin
          wb_valid_d = (rd_q != 5'd0);
          wb_rd_d    = rd_q;
          wb_data_d  = load_result;
          state_d    = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      StErr: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rd_q       <= 5'd0;
      ctrl_q     <= 3'd0;
      lane_q     <= 2'd0;
      mem_addr_q <= 32'h0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'h0;
      mis_q      <= 1'b0;
      mis_addr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      ctrl_q     <= ctrl_d;
      lane_q     <= lane_d;
      mem_addr_q <= mem_addr_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
    end
  end

  // Handshake signals are plain state decodes; everything else is registered.
  assign ld_ready        = (state_q == StIdle);
  assign mem_req_valid   = (state_q == StReq);
  assign mem_addr        = mem_addr_q;
  assign wb_valid        = wb_valid_q;
  assign wb_rd           = wb_rd_q;
  assign wb_data         = wb_data_q;
  assign misaligned      = mis_q;
  assign misaligned_addr = mis_addr_q;

endmodule

// File: doc/load_unit_ctrl.md
# load_unit_ctrl

Sequencing controller for RV32I loads. Accepts a decoded load (base register value, 12-bit offset, destination register, `load_control` from the load decoder) and computes the effective address. It then runs a valid/ready request to data memory, waits for the response, and extracts and extends the addressed byte, halfword or word. The result is delivered as a one-cycle register-file write-back. It sits between the load decoder/register-read stage and the data-memory port.

## Interface
Parameters:
- none (32-bit datapath fixed)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- ld_valid  in  1  load request present
- ld_ready  out  1  controller can accept; high only in IDLE
- ld_rs1_data  in  32  base register value
- ld_imm  in  12  signed offset
- ld_rd  in  5  destination register
- ld_control  in  3  `LB`/`LH`/`LW`/`LBU`/`LHU` encodings from processor_defines.sv
- mem_req_valid  out  1  memory read request
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  32  word-aligned address {ea[31:2],2'b00}
- mem_rsp_valid  in  1  read data valid
- mem_rsp_data  in  32  little-endian read word
- wb_valid  out  1  one-cycle write-back strobe
- wb_rd  out  5  write-back register
- wb_data  out  32  extended load result
- misaligned  out  1  one-cycle misaligned-load strobe
- misaligned_addr  out  32  offending effective address

## Operation
- States: IDLE, REQ, WAIT, DONE, ERR.
- IDLE: on ld_valid, latch rd and control. Compute ea = ld_rs1_data + sext(ld_imm), mod 2^32 (wraps, no overflow flag).
  - Misaligned (LH/LHU with ea[0]=1, or LW with ea[1:0]≠0): go to ERR.
  - Otherwise: go to REQ.
- ERR: misaligned=1 and misaligned_addr=ea for one cycle. No memory request is issued. Next state is IDLE.
- REQ: mem_req_valid=1. mem_addr is held stable until mem_req_ready. On handshake, go to WAIT.
- WAIT: on mem_rsp_valid, compute the result, register it, and go to DONE. mem_rsp_valid is ignored in every other state.
- DONE: wb_valid=1 for exactly one cycle, then IDLE. If latched rd=0, wb_valid stays 0; DONE still lasts one cycle.
- Extraction, lane = ea[1:0]:
  - LB: sext(byte[lane]).
  - LBU: zext(byte[lane]).
  - LH: sext(half[ea[1]]).
  - LHU: zext(half[ea[1]]).
  - LW: full word.
- Any other control encoding is treated as LW.
- One load in flight maximum. ld_ready is the decode of IDLE only.
- The write-back path has no backpressure.

## Timing
- Reset values: state IDLE, ld_ready=1. mem_req_valid, mem_addr, wb_valid, wb_rd, wb_data, misaligned, misaligned_addr all 0.
- Reset asserted in any state returns to IDLE immediately. A response arriving after reset is ignored.
- Best-case latency, with the load accepted at cycle 0:
  - mem_req_valid high in cycle 1.
  - mem_req_ready in cycle 1 moves to WAIT in cycle 2.
  - mem_rsp_valid in cycle 2 gives wb_valid in cycle 3.
  - ld_ready returns high in cycle 4.
- Each cycle of mem_req_ready=0 or of response delay adds one cycle.
- A response in the same cycle as the request handshake is not legal. Memory returns data no earlier than the cycle after acceptance.
- Misaligned: accept at cycle 0, misaligned pulse in cycle 1, ld_ready high in cycle 2.
- All outputs are registered except ld_ready and mem_req_valid, which are state decodes.

## Test plan
- LW: rs1=0x1000, imm=0x004, rd=5. mem_addr=0x1004; rsp 0xDEADBEEF → wb_valid in cycle 3, wb_rd=5, wb_data=0xDEADBEEF.
- LB/LBU: rs1=0x2000, imm=0xFFF (−1). mem_addr=0x1FFC, lane 3; rsp 0x80123456.
  - LB → wb_data=0xFFFFFF80.
  - LBU → 0x00000080.
- LH/LHU: ea=0x3002; rsp 0x9ABC1234.
  - LH → 0xFFFF9ABC.
  - LHU → 0x00009ABC.
  - LH at ea=0x3003 → misaligned=1, misaligned_addr=0x3003, mem_req_valid never asserted, wb_valid stays 0.
- Backpressure: mem_req_ready low for 3 cycles. mem_req_valid and mem_addr stay stable throughout, and exactly one handshake occurs. A spurious mem_rsp_valid during REQ is ignored.
- rd=0: LW completes the handshake, wb_valid stays 0, and ld_ready returns high on schedule.
- Reset mid-operation: assert rst_n=0 in WAIT.
  - All outputs go to 0 immediately and ld_ready goes to 1.
  - A later mem_rsp_valid produces no wb_valid.
  - A new LW then completes normally.
